// File: rtl/delay_tap_chain.sv
// delay_tap_chain
//   CHANNELS independent 2-phase request delay lines. Each channel shifts its
//   input level through a MAX_DELAY-deep shift register and taps it at a
//   runtime-programmable depth d (1..MAX_DELAY). A small config FSM changes
//   a channel's delay only while that channel is quiet, so retargeting the
//   tap never creates or drops an edge on the output.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   inR        request levels, one per channel
//   outR       delayed request levels
//   pending    1 = channel has a transition in flight
//   cfg_we     one-cycle config write strobe
//   cfg_ch     target channel of the write
//   cfg_delay  requested delay in cycles (clamped to 1..MAX_DELAY)
//   cfg_busy   1 = a config write is waiting to be applied

// One channel: shift register, delay register and tap select.
module delay_tap_lane #(
    parameter int MAX_DELAY = 16,
    parameter int RST_DELAY = 6,
    parameter int DW        = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inBit,
    input  logic          loadEn,
    input  logic [DW-1:0] loadVal,
    output logic          outBit,
    output logic          quiet
);
    logic [MAX_DELAY-1:0] sr;
    logic [DW-1:0]        d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
            d  <= DW'(RST_DELAY);
        end else begin
            sr[0] <= inBit;
            for (int i = 1; i < MAX_DELAY; i++) sr[i] <= sr[i-1];
            if (loadEn) d <= loadVal;
        end
    end

    // Tap select written as a compare chain so the index width never has
    // to match the register depth.
    always_comb begin
        outBit = 1'b0;
        for (int i = 0; i < MAX_DELAY; i++)
            if (d == DW'(i + 1)) outBit = sr[i];
    end

    // Quiet when the input and every stored bit agree: any tap gives the
    // same level, so moving the tap is invisible on the output.
    assign quiet = (&{sr, inBit}) | ~(|{sr, inBit});
endmodule

module delay_tap_chain #(
    parameter int CHANNELS  = 4,
    parameter int MAX_DELAY = 16,
    parameter int RST_DELAY = 6,
    parameter int DW        = 5,
    parameter int CW        = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] inR,
    output logic [CHANNELS-1:0] outR,
    output logic [CHANNELS-1:0] pending,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [DW-1:0]       cfg_delay,
    output logic                cfg_busy
);
    typedef enum logic [1:0] {IDLE, WAIT, APPLY} cfgState_t;

    cfgState_t           state, stateNext;
    logic [CW-1:0]       latCh;
    logic [DW-1:0]       latDelay;
    logic [DW-1:0]       clampDelay;
    logic [CHANNELS-1:0] quietVec;
    logic                chValid;
    logic                accept;
    logic                selQuiet;

    assign chValid = (32'(cfg_ch) < CHANNELS);

    always_comb begin
        clampDelay = cfg_delay;
        if (cfg_delay == '0)
            clampDelay = DW'(1);
        else if (32'(cfg_delay) > MAX_DELAY)
            clampDelay = DW'(MAX_DELAY);
    end

    always_comb begin
        selQuiet = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
            if (latCh == CW'(c)) selQuiet = quietVec[c];
    end

    // Writes are only taken in IDLE; anything arriving while busy is dropped.
    assign accept = (state == IDLE) && cfg_we && chValid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            latCh    <= '0;
            latDelay <= DW'(RST_DELAY);
        end else begin
            state <= stateNext;
            if (accept) begin
                latCh    <= cfg_ch;
                latDelay <= clampDelay;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept)   stateNext = WAIT;
            WAIT:    if (selQuiet) stateNext = APPLY;
            APPLY:                 stateNext = IDLE;
            default:               stateNext = IDLE;
        endcase
    end

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : gLane
            delay_tap_lane #(
                .MAX_DELAY(MAX_DELAY),
                .RST_DELAY(RST_DELAY),
                .DW       (DW)
            ) uLane (
                .clk    (clk),
                .rst    (rst),
                .inBit  (inR[c]),
                .loadEn (state == APPLY && latCh == CW'(c)),
                .loadVal(latDelay),
                .outBit (outR[c]),
                .quiet  (quietVec[c])
            );
        end
    endgenerate

    // pending is forced low while reset is held, even if inR is high.
    assign pending  = ~quietVec & {CHANNELS{rst}};
    assign cfg_busy = (state != IDLE);
endmodule
